axil_reg_master: RTL and testbench

AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write or read transactions and returns one response per command. It sits between control logic (sequencers, bring-up FSMs) and `axi_lite_slave` config-register banks, so registers can be programmed and read back from RTL without a host. Only one transaction is outstanding at a time. An optional watchdog aborts transactions the slave never completes.

---
 rtl/axil_master_pkg.sv | 18 +
 rtl/axil_reg_master.sv | 154 +++++++++++++++
 tb/tb_axil_reg_master.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite register master.
package axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/axil_reg_master.sv
// Single-outstanding AXI4-Lite initiator for register commands.
// Optional watchdog abort: define AXIL_MASTER_TIMEOUT_EN.
module axil_reg_master
    import axil_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    state_t state, nxt, state_n;

    logic                aw_done, w_done;
    logic                aw_hs, w_hs;
    logic                abort;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    // rstn gate keeps cmd_ready low for the whole reset pulse
    assign cmd_ready     = rstn && (state == IDLE);
    assign m_axi_awvalid = (state == WR) && !aw_done;
    assign m_axi_wvalid  = (state == WR) && !w_done;
    assign m_axi_bready  = (state == WB);
    assign m_axi_arvalid = (state == RA);
    assign m_axi_rready  = (state == RD);
    assign rsp_valid     = (state == RSP);

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (cmd_valid) nxt = cmd_write ? WR : RA;
            WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) nxt = WB;
            WB:   if (m_axi_bvalid) nxt = RSP;
            RA:   if (m_axi_arready) nxt = RD;
            RD:   if (m_axi_rvalid) nxt = RSP;
            RSP:  if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign state_n = abort ? RSP : nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            state <= state_n;
            if (cmd_valid && cmd_ready) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (abort) begin
                rsp_rdata <= '0;
                rsp_resp  <= RESP_SLVERR;
            end else if (state == WB && m_axi_bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end else if (state == RD && m_axi_rvalid) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             tmo_q;

    assign busy = (state == WR) || (state == WB) ||
                  (state == RA) || (state == RD);
    // a completing handshake in the final cycle wins over the abort
    assign abort = busy && (nxt == state) &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = tmo_q;

    always_ff @(posedge clk) begin
        if (!rstn || !busy) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            tmo_q <= 1'b0;
        else if (state != RSP && state_n == RSP)
            tmo_q <= abort;
    end
`else
    logic unused_cfg;

    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master with an inline AXI4-Lite slave.
module tb_axil_reg_master;

    logic        clk;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int n_pass  = 0;
    int n_total = 0;

    axil_reg_master #(
        .ADDR_W(6),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr),
        .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_araddr(araddr),
        .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata),
        .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave model: register file plus knobs for ready skew and faults
    int          aw_dly = 0, w_dly = 0;
    int          aw_cnt, w_cnt;
    logic        ar_block = 1'b0;
    logic        r_err    = 1'b0;
    logic        b_hold   = 1'b0;
    logic [31:0] mem [16];
    logic [5:0]  sa;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic        sga, sgw;
    int          n_aw = 0, n_w = 0, n_b = 0, arv_cyc = 0;
    logic        aw_hs, w_hs, ar_hs;
    logic [5:0]  a_now;
    logic [31:0] d_now;
    logic [3:0]  s_now;

    assign awready = (aw_cnt >= aw_dly);
    assign wready  = (w_cnt >= w_dly);
    assign arready = !ar_block;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign a_now   = aw_hs ? awaddr : sa;
    assign d_now   = w_hs ? wdata : sd;
    assign s_now   = w_hs ? wstrb : ss;

    always @(posedge clk) begin
        arv_cyc <= arv_cyc + (arvalid ? 1 : 0);
        if (!rstn) begin
            sga    <= 1'b0;
            sgw    <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            aw_cnt <= 0;
            w_cnt  <= 0;
            bresp  <= 2'b00;
            rresp  <= 2'b00;
            rdata  <= 32'h0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            else if (aw_hs)          aw_cnt <= 0;
            if (wvalid && !wready)   w_cnt <= w_cnt + 1;
            else if (w_hs)           w_cnt <= 0;
            if (aw_hs) begin
                sa <= awaddr; sga <= 1'b1; n_aw <= n_aw + 1;
            end
            if (w_hs) begin
                sd <= wdata; ss <= wstrb; sgw <= 1'b1; n_w <= n_w + 1;
            end
            if ((sga || aw_hs) && (sgw || w_hs)) begin
                for (int b = 0; b < 4; b++)
                    if (s_now[b]) mem[a_now[5:2]][8*b +: 8] <= d_now[8*b +: 8];
                sga <= 1'b0;
                sgw <= 1'b0;
                bresp <= 2'b00;
                if (!b_hold) bvalid <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; n_b <= n_b + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= r_err ? 32'h1234_5678 : mem[araddr[5:2]];
                rresp  <= r_err ? 2'b10 : 2'b00;
            end
        end
    end

    // issue one command and consume its response; lat counts the cycle
    // after acceptance as 1, v1 is {awvalid,wvalid,arvalid} in that cycle
    task automatic do_cmd(input logic wr, input logic [5:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input int stall_max,
                          output logic [31:0] rd, output logic [1:0] rs,
                          output logic to, output int lat,
                          output logic [2:0] v1, output int unstable);
        int k;
        int stall;
        rd = 32'hX; rs = 2'bXX; to = 1'bX; lat = 0; v1 = 3'bXXX;
        unstable = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1",
                     cmd_ready, k);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        v1  = {awvalid, wvalid, arvalid};
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) begin
            n_total++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1",
                     rsp_valid, lat);
            return;
        end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs ||
                rsp_timeout !== to)
                unstable++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cmd_ready !== 1'b0)
            $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
        else n_pass++;
        n_total++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0)
            $display("FAIL reset_valids: got %b, required 000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        else n_pass++;
        n_total++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0)
            $display("FAIL reset_rsp: got %h/%b/%b, required 0/00/0",
                     rsp_rdata, rsp_resp, rsp_timeout);
        else n_pass++;
        n_total++;
        if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== 54'h0)
            $display("FAIL reset_payload: got aw=%h ar=%h w=%h s=%h, required 0",
                     awaddr, araddr, wdata, wstrb);
        else n_pass++;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (cmd_ready !== 1'b1)
            $display("FAIL release_cmd_ready: got %b, required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic [1:0] rs; logic to;
        int lat, un; logic [2:0] v1;
        do_cmd(1'b1, 6'h04, 32'hDEAD_BEEF, 4'hF, 0, rd, rs, to, lat, v1, un);
        n_total++;
        if (v1 !== 3'b110)
            $display("FAIL wr_valids_n1: got %b, required 110", v1);
        else n_pass++;
        n_total++;
        if (lat !== 3)
            $display("FAIL wr_latency: got %0d, required 3", lat);
        else n_pass++;
        n_total++;
        if ({rd, rs, to} !== {32'h0, 2'b00, 1'b0})
            $display("FAIL wr_rsp: got %h/%b/%b, required 0/00/0", rd, rs, to);
        else n_pass++;
        n_total++;
        if (cmd_ready !== 1'b1)
            $display("FAIL wr_next_ready: got %b, required 1", cmd_ready);
        else n_pass++;
        do_cmd(1'b0, 6'h04, 32'h0, 4'h0, 0, rd, rs, to, lat, v1, un);
        n_total++;
        if (v1 !== 3'b001)
            $display("FAIL rd_valids_n1: got %b, required 001", v1);
        else n_pass++;
        n_total++;
        if (lat !== 3)
            $display("FAIL rd_latency: got %0d, required 3", lat);
        else n_pass++;
        n_total++;
        if ({rd, rs, to} !== {32'hDEAD_BEEF, 2'b00, 1'b0})
            $display("FAIL rd_rsp: got %h/%b/%b, required deadbeef/00/0",
                     rd, rs, to);
        else n_pass++;
    endtask

    task automatic test_ready_skew();
        logic [31:0] rd; logic [1:0] rs; logic to;
        int lat, un; logic [2:0] v1;
        int aw0, w0, b0;
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        aw_dly = 4; w_dly = 1;
        do_cmd(1'b1, 6'h08, 32'hA5A5_0F0F, 4'hF, 0, rd, rs, to, lat, v1, un);
        aw_dly = 0; w_dly = 0;
        n_total++;
        if ({n_aw - aw0, n_w - w0, n_b - b0} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL skew_handshakes: got aw=%0d w=%0d b=%0d, required 1/1/1",
                     n_aw - aw0, n_w - w0, n_b - b0);
        else n_pass++;
        n_total++;
        if (lat !== 7 || rs !== 2'b00)
            $display("FAIL skew_rsp: got lat=%0d resp=%b, required 7/00", lat, rs);
        else n_pass++;
        do_cmd(1'b1, 6'h08, 32'h1111_2222, 4'b0011, 0, rd, rs, to, lat, v1, un);
        do_cmd(1'b0, 6'h08, 32'h0, 4'h0, 0, rd, rs, to, lat, v1, un);
        n_total++;
        if (rd !== 32'hA5A5_2222)
            $display("FAIL strobe_merge: got %h, required a5a52222", rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] rs; logic to;
        int lat, un, un_tot, bad_wr;
        logic [2:0] v1;
        logic [31:0] l;
        logic [31:0] exp_w [16];
        l = 32'hACE1_1234;
        un_tot = 0; bad_wr = 0;
        for (int i = 0; i < 16; i++) begin
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
            exp_w[i] = l;
            do_cmd(1'b1, 6'(i * 4), l, 4'hF, 3, rd, rs, to, lat, v1, un);
            un_tot += un;
            if (rs !== 2'b00 || rd !== 32'h0) bad_wr++;
        end
        n_total++;
        if (bad_wr !== 0)
            $display("FAIL b2b_write_rsp: got %0d bad, required 0", bad_wr);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b0, 6'(i * 4), 32'h0, 4'h0, 3, rd, rs, to, lat, v1, un);
            un_tot += un;
            n_total++;
            if (rd !== exp_w[i] || rs !== 2'b00)
                $display("FAIL b2b_read[%0d]: got %h/%b, required %h/00",
                         i, rd, rs, exp_w[i]);
            else n_pass++;
        end
        n_total++;
        if (un_tot !== 0)
            $display("FAIL rsp_stable: got %0d unstable cycles, required 0",
                     un_tot);
        else n_pass++;
    endtask

    task automatic test_rresp_err();
        logic [31:0] rd; logic [1:0] rs; logic to;
        int lat, un; logic [2:0] v1;
        r_err = 1'b1;
        do_cmd(1'b0, 6'h10, 32'h0, 4'h0, 0, rd, rs, to, lat, v1, un);
        r_err = 1'b0;
        n_total++;
        if ({rd, rs, to} !== {32'h1234_5678, 2'b10, 1'b0})
            $display("FAIL rresp_err: got %h/%b/%b, required 12345678/10/0",
                     rd, rs, to);
        else n_pass++;
    endtask

    task automatic test_reset_in_wb();
        int k;
        b_hold = 1'b1;
        cmd_write = 1'b1; cmd_addr = 6'h20;
        cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!bready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        n_total++;
        if (bready !== 1'b1)
            $display("FAIL reach_wb: bready=%b, required 1", bready);
        else n_pass++;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        b_hold = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({awvalid, wvalid, bready, rsp_valid, cmd_ready} !== 5'b00001)
            $display("FAIL reset_in_wb: got aw/w/b/rsp/cmd=%b, required 00001",
                     {awvalid, wvalid, bready, rsp_valid, cmd_ready});
        else n_pass++;
    endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] rs; logic to;
        int lat, un, c0; logic [2:0] v1;
        ar_block = 1'b1;
        c0 = arv_cyc;
        do_cmd(1'b0, 6'h0C, 32'h0, 4'h0, 0, rd, rs, to, lat, v1, un);
        ar_block = 1'b0;
        n_total++;
        if (arv_cyc - c0 !== 16 || lat !== 17)
            $display("FAIL tmo_window: got arvalid=%0d lat=%0d, required 16/17",
                     arv_cyc - c0, lat);
        else n_pass++;
        n_total++;
        if ({rd, rs, to, arvalid} !== {32'h0, 2'b10, 1'b1, 1'b0})
            $display("FAIL tmo_rsp: got %h/%b/%b arvalid=%b, required 0/10/1/0",
                     rd, rs, to, arvalid);
        else n_pass++;
        do_cmd(1'b0, 6'h0C, 32'h0, 4'h0, 0, rd, rs, to, lat, v1, un);
        n_total++;
        if (rs !== 2'b00 || to !== 1'b0 || lat !== 3)
            $display("FAIL tmo_recover: got resp=%b to=%b lat=%0d, required 00/0/3",
                     rs, to, lat);
        else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_ready_skew();
        test_back_to_back();
        test_rresp_err();
        test_reset_in_wb();
`ifdef AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
